// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: segment bit order,
// glyph constants and a hex-to-glyph helper for producers.
package seg_scan_ctrl_pkg;

   localparam int NUM_DIGITS_DEF = 8;
   localparam int SEG_W          = 8;

   // Segment bit positions within a digit byte, ordered {a,b,c,d,e,f,g,dp}
   localparam int SEG_A_BIT  = 7;
   localparam int SEG_B_BIT  = 6;
   localparam int SEG_C_BIT  = 5;
   localparam int SEG_D_BIT  = 4;
   localparam int SEG_E_BIT  = 3;
   localparam int SEG_F_BIT  = 2;
   localparam int SEG_G_BIT  = 1;
   localparam int SEG_DP_BIT = 0;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_BLANK = 8'h00;
   localparam seg_t SEG_0     = 8'b1111_1100;
   localparam seg_t SEG_1     = 8'b0110_0000;
   localparam seg_t SEG_2     = 8'b1101_1010;
   localparam seg_t SEG_3     = 8'b1111_0010;
   localparam seg_t SEG_4     = 8'b0110_0110;
   localparam seg_t SEG_5     = 8'b1011_0110;
   localparam seg_t SEG_6     = 8'b1011_1110;
   localparam seg_t SEG_7     = 8'b1110_0000;
   localparam seg_t SEG_8     = 8'b1111_1110;
   localparam seg_t SEG_9     = 8'b1111_0110;

   function automatic seg_t hex_glyph(input logic [3:0] val);
      seg_t g;
      case (val)
         4'h0: g = SEG_0;
         4'h1: g = SEG_1;
         4'h2: g = SEG_2;
         4'h3: g = SEG_3;
         4'h4: g = SEG_4;
         4'h5: g = SEG_5;
         4'h6: g = SEG_6;
         4'h7: g = SEG_7;
         4'h8: g = SEG_8;
         4'h9: g = SEG_9;
         4'hA: g = 8'b1110_1110;
         4'hB: g = 8'b0011_1110;
         4'hC: g = 8'b1001_1100;
         4'hD: g = 8'b0111_1010;
         4'hE: g = 8'b1001_1110;
         default: g = 8'b1000_1110;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick_div.sv
// Free-running divider: tick is high for one cycle out of every DIV cycles,
// on the last count of each period.
module tick_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Double-buffered 8-digit seven-segment scan controller with per-digit enable,
// blink and start-of-slot blanking; sole driver of seg_out and tubsel.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = NUM_DIGITS_DEF,
   parameter int SCAN_DIV   = 100000,
   parameter int BLANK_CYC  = 4,
   parameter int BLINK_DIV  = 250
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [8*NUM_DIGITS-1:0]       frame_data,
   input  logic [NUM_DIGITS-1:0]         frame_en,
   input  logic [NUM_DIGITS-1:0]         frame_blink,
   input  logic                          frame_valid,
   output logic                          frame_ready,
   output logic [SEG_W-1:0]              seg_out,
   output logic [NUM_DIGITS-1:0]         tubsel,
   output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
   output logic                          frame_wrap
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int BLK_W = $clog2(BLANK_CYC + 1);
   localparam int WRP_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BLK_W-1:0] BLANK_END = BLK_W'(BLANK_CYC);
   localparam logic [WRP_W-1:0] WRAP_LAST = WRP_W'(BLINK_DIV - 1);

   typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] frame_t;

   logic tick;

   tick_div #(
      .DIV (SCAN_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Handshake: a frame transfers on any edge where frame_valid && frame_ready.
   // frame_ready low means the shadow buffer holds a frame not yet displayed;
   // it returns high on the frame wrap that moves shadow into active.
   frame_t                  active_data_q, active_data_d;
   frame_t                  shadow_data_q, shadow_data_d;
   logic [NUM_DIGITS-1:0]   active_en_q, active_en_d;
   logic [NUM_DIGITS-1:0]   active_blink_q, active_blink_d;
   logic [NUM_DIGITS-1:0]   shadow_en_q, shadow_en_d;
   logic [NUM_DIGITS-1:0]   shadow_blink_q, shadow_blink_d;
   logic                    ready_q, ready_d;
   logic [IDX_W-1:0]        scan_q, scan_d;
   logic [BLK_W-1:0]        blank_q, blank_d;
   logic [WRP_W-1:0]        wrap_cnt_q, wrap_cnt_d;
   logic                    phase_q, phase_d;
   logic                    wrap_q;
   logic [SEG_W-1:0]        seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   tub_q, tub_d;

   logic wrap;
   logic capture;
   logic promote;

   always_comb begin
      wrap           = tick && (scan_q == LAST_IDX);
      capture        = frame_valid && ready_q;
      promote        = wrap && !ready_q;

      scan_d         = scan_q;
      blank_d        = blank_q;
      wrap_cnt_d     = wrap_cnt_q;
      phase_d        = phase_q;
      ready_d        = ready_q;
      shadow_data_d  = shadow_data_q;
      shadow_en_d    = shadow_en_q;
      shadow_blink_d = shadow_blink_q;
      active_data_d  = active_data_q;
      active_en_d    = active_en_q;
      active_blink_d = active_blink_q;

      if (tick) begin
         scan_d  = wrap ? '0 : scan_q + 1'b1;
         blank_d = '0;
      end else if (blank_q < BLANK_END) begin
         blank_d = blank_q + 1'b1;
      end

      if (wrap) begin
         if (wrap_cnt_q == WRAP_LAST) begin
            wrap_cnt_d = '0;
            phase_d    = !phase_q;
         end else begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
         end
      end

      // capture needs ready high and promote needs it low, so they never collide
      if (capture) begin
         shadow_data_d  = frame_data;
         shadow_en_d    = frame_en;
         shadow_blink_d = frame_blink;
         ready_d        = 1'b0;
      end else if (promote) begin
         active_data_d  = shadow_data_q;
         active_en_d    = shadow_en_q;
         active_blink_d = shadow_blink_q;
         ready_d        = 1'b1;
      end
   end

   // Drive values are computed from next state so the pins line up with scan_idx
   always_comb begin
      seg_d = '0;
      tub_d = '0;
      if (blank_d >= BLANK_END && active_en_d[scan_d]) begin
         tub_d[scan_d] = 1'b1;
         if (!(active_blink_d[scan_d] && phase_d)) begin
            seg_d = active_data_d[scan_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_data_q  <= '0;
         active_en_q    <= '0;
         active_blink_q <= '0;
         shadow_data_q  <= '0;
         shadow_en_q    <= '0;
         shadow_blink_q <= '0;
         ready_q        <= 1'b1;
         scan_q         <= '0;
         blank_q        <= '0;
         wrap_cnt_q     <= '0;
         phase_q        <= 1'b0;
         wrap_q         <= 1'b0;
         seg_q          <= '0;
         tub_q          <= '0;
      end else begin
         active_data_q  <= active_data_d;
         active_en_q    <= active_en_d;
         active_blink_q <= active_blink_d;
         shadow_data_q  <= shadow_data_d;
         shadow_en_q    <= shadow_en_d;
         shadow_blink_q <= shadow_blink_d;
         ready_q        <= ready_d;
         scan_q         <= scan_d;
         blank_q        <= blank_d;
         wrap_cnt_q     <= wrap_cnt_d;
         phase_q        <= phase_d;
         wrap_q         <= wrap;
         seg_q          <= seg_d;
         tub_q          <= tub_d;
      end
   end

   assign frame_ready = ready_q;
   assign seg_out     = seg_q;
   assign tubsel      = tub_q;
   assign scan_idx    = scan_q;
   assign frame_wrap  = wrap_q;

endmodule
